// File: rtl/ex_mdu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit:
// operation encodings and the controller state type.
package ex_mdu_pkg;

    typedef enum logic [1:0] {
        OpMult  = 2'b00,
        OpMultu = 2'b01,
        OpDiv   = 2'b10,
        OpDivu  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StDone
    } mdu_state_e;

endpackage

// File: rtl/ex_mdu_if.sv
// Request/result bundle between the execute stage and the multiply/divide unit.
interface ex_mdu_if #(
    parameter int unsigned DATA_W = 32
);
    logic              START_I;
    logic [1:0]        MDU_OP_I;
    logic [DATA_W-1:0] REG1_DATA_I;
    logic [DATA_W-1:0] REG2_DATA_I;
    logic              CANCEL_I;
    logic              STALL_REQ_O;
    logic              DONE_O;
    logic [DATA_W-1:0] HI_O;
    logic [DATA_W-1:0] LO_O;
    logic              BUSY_O;

    modport master (
        output START_I, MDU_OP_I, REG1_DATA_I, REG2_DATA_I, CANCEL_I,
        input  STALL_REQ_O, DONE_O, HI_O, LO_O, BUSY_O
    );

    modport slave (
        input  START_I, MDU_OP_I, REG1_DATA_I, REG2_DATA_I, CANCEL_I,
        output STALL_REQ_O, DONE_O, HI_O, LO_O, BUSY_O
    );
endinterface

// File: rtl/mdu_div.sv
// Radix-2 restoring divider on unsigned magnitudes, one quotient bit per cycle.
// The start edge already performs the first iteration; done is high after the last one.
module mdu_div #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              flush,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);
    localparam int unsigned CntW = $clog2(DATA_W + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DATA_W);

    logic              busy_q, busy_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [DATA_W-1:0] rem_in, quo_in, dvs_in;
    logic [DATA_W:0]   shifted, dvs_ext, diff;

    assign done      = busy_q && (cnt_q == CntLast);
    assign quotient  = quo_q;
    assign remainder = rem_q;

    always_comb begin
        rem_in  = start ? '0 : rem_q;
        quo_in  = start ? dividend : quo_q;
        dvs_in  = start ? divisor : dvs_q;
        shifted = {rem_in, quo_in[DATA_W-1]};
        dvs_ext = {1'b0, dvs_in};
        diff    = shifted - dvs_ext;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        if (flush) begin
            busy_d = 1'b0;
        end else if (start || (busy_q && !done)) begin
            busy_d = 1'b1;
            cnt_d  = start ? CntW'(1) : cnt_q + CntW'(1);
            dvs_d  = dvs_in;
            // Restore by simply keeping the shifted partial remainder.
            if (shifted >= dvs_ext) begin
                rem_d = diff[DATA_W-1:0];
                quo_d = {quo_in[DATA_W-2:0], 1'b1};
            end else begin
                rem_d = shifted[DATA_W-1:0];
                quo_d = {quo_in[DATA_W-2:0], 1'b0};
            end
        end else if (done) begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
        end
    end

endmodule

// File: rtl/ex_mdu.sv
// Execute-stage multiply/divide unit: pipelined multiplier inline, iterative divider in
// mdu_div, results held in HI/LO until the next completed operation.
module ex_mdu
    import ex_mdu_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MUL_STAGES = 2
) (
    input  logic     CLK,
    input  logic     RST,
    ex_mdu_if.slave  mdu
);
    localparam int unsigned ProdW = 2 * DATA_W;
    localparam logic [1:0] MulLast = 2'(MUL_STAGES >= 2 ? MUL_STAGES - 2 : 0);

    mdu_state_e        state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic              sgn_q, sgn_d;
    logic [1:0]        cnt_q, cnt_d;

    logic              op_signed, op_div, accept;
    logic [DATA_W-1:0] mul_a, mul_b;
    logic              mul_sgn;
    logic [ProdW-1:0]  mul_a_ext, mul_b_ext, prod_full, mul_res;
    logic [DATA_W-1:0] a_mag, b_mag, quo, rem, div_hi, div_lo;
    logic              div_start, div_done, q_neg, r_neg;

    always_comb begin
        op_signed = 1'b0;
        op_div    = 1'b0;
        case (mdu.MDU_OP_I)
            OpMult:  op_signed = 1'b1;
            OpDiv:   begin op_signed = 1'b1; op_div = 1'b1; end
            OpDivu:  op_div = 1'b1;
            default: ;
        endcase
    end

    assign accept = (state_q == StIdle) && mdu.START_I && !mdu.CANCEL_I;

    // A single-stage multiplier takes its product straight from the request operands.
    always_comb begin
        if (MUL_STAGES == 1) begin
            mul_a   = mdu.REG1_DATA_I;
            mul_b   = mdu.REG2_DATA_I;
            mul_sgn = op_signed;
        end else begin
            mul_a   = a_q;
            mul_b   = b_q;
            mul_sgn = sgn_q;
        end
    end

    assign mul_a_ext = {{DATA_W{mul_sgn & mul_a[DATA_W-1]}}, mul_a};
    assign mul_b_ext = {{DATA_W{mul_sgn & mul_b[DATA_W-1]}}, mul_b};
    assign prod_full = mul_a_ext * mul_b_ext;

    if (MUL_STAGES > 2) begin : g_mul_pipe
        logic [ProdW-1:0] pipe_q [MUL_STAGES-2];
        always_ff @(posedge CLK) begin
            if (RST) begin
                for (int unsigned i = 0; i < MUL_STAGES - 2; i++) pipe_q[i] <= '0;
            end else begin
                pipe_q[0] <= prod_full;
                for (int unsigned i = 1; i < MUL_STAGES - 2; i++) pipe_q[i] <= pipe_q[i-1];
            end
        end
        assign mul_res = pipe_q[MUL_STAGES-3];
    end else begin : g_mul_comb
        assign mul_res = prod_full;
    end

    assign a_mag     = (op_signed && mdu.REG1_DATA_I[DATA_W-1]) ?
                       {DATA_W{1'b0}} - mdu.REG1_DATA_I : mdu.REG1_DATA_I;
    assign b_mag     = (op_signed && mdu.REG2_DATA_I[DATA_W-1]) ?
                       {DATA_W{1'b0}} - mdu.REG2_DATA_I : mdu.REG2_DATA_I;
    assign div_start = accept && op_div;

    mdu_div #(
        .DATA_W (DATA_W)
    ) u_div (
        .clk       (CLK),
        .rst       (RST),
        .start     (div_start),
        .flush     (mdu.CANCEL_I),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .done      (div_done),
        .quotient  (quo),
        .remainder (rem)
    );

    // Sign fixup happens on the edge that enters DONE.
    always_comb begin
        q_neg = sgn_q & (a_q[DATA_W-1] ^ b_q[DATA_W-1]);
        r_neg = sgn_q & a_q[DATA_W-1];
        if (b_q == '0) begin
            div_lo = '1;
            div_hi = a_q;
        end else begin
            div_lo = q_neg ? {DATA_W{1'b0}} - quo : quo;
            div_hi = r_neg ? {DATA_W{1'b0}} - rem : rem;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (mdu.CANCEL_I) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (mdu.START_I) begin
                        a_d   = mdu.REG1_DATA_I;
                        b_d   = mdu.REG2_DATA_I;
                        sgn_d = op_signed;
                        cnt_d = '0;
                        if (op_div) begin
                            state_d = StDiv;
                        end else if (MUL_STAGES == 1) begin
                            state_d = StDone;
                            hi_d    = mul_res[ProdW-1:DATA_W];
                            lo_d    = mul_res[DATA_W-1:0];
                        end else begin
                            state_d = StMul;
                        end
                    end
                end
                StMul: begin
                    if (cnt_q == MulLast) begin
                        state_d = StDone;
                        hi_d    = mul_res[ProdW-1:DATA_W];
                        lo_d    = mul_res[DATA_W-1:0];
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
                StDiv: begin
                    if (div_done) begin
                        state_d = StDone;
                        hi_d    = div_hi;
                        lo_d    = div_lo;
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign mdu.DONE_O      = (state_q == StDone);
    assign mdu.BUSY_O      = (state_q != StIdle);
    assign mdu.STALL_REQ_O = !RST && (accept || state_q == StMul || state_q == StDiv);
    assign mdu.HI_O        = hi_q;
    assign mdu.LO_O        = lo_q;

endmodule
